// File: rtl/network_div_pkg.sv
// Shared constants and state encoding for the sequential 29s/13s -> 16s divider.
package network_div_pkg;

  localparam int DIN0_W = 29;
  localparam int DIN1_W = 13;
  localparam int DOUT_W = 16;
  localparam int ITER   = 29;
  localparam int CNT_W  = 5;

  localparam logic [DOUT_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DOUT_W-1:0] Q_MIN = 16'h8000;

  // Largest quotient magnitudes representable for each result sign.
  localparam logic [DIN0_W-1:0] MAG_POS_LIM = 29'd32767;
  localparam logic [DIN0_W-1:0] MAG_NEG_LIM = 29'd32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/network_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module network_div_step
  import network_div_pkg::*;
(
  input  logic [DIN1_W-1:0] rem_in,
  input  logic              bit_in,
  input  logic [DIN1_W-1:0] divisor,
  output logic [DIN1_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DIN1_W:0] trial;

  always_comb begin
    trial = {rem_in, bit_in};
    if (trial >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      rem_out = DIN1_W'(trial - {1'b0, divisor});
    end else begin
      q_bit   = 1'b0;
      rem_out = trial[DIN1_W-1:0];
    end
  end

endmodule

// File: rtl/network_div_29s_13s_16_seq.sv
// Sequential signed divider: 29 restoring steps on magnitudes, then sign fix-up,
// saturation and divide-by-zero handling, with valid/ready handshakes on both sides.
module network_div_29s_13s_16_seq
  import network_div_pkg::*;
#(
  parameter int ID         = 32'd1,
  parameter int din0_WIDTH = 32'd29,
  parameter int din1_WIDTH = 32'd13,
  parameter int dout_WIDTH = 32'd16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dz
);

  logic unused_id;
  assign unused_id = ^ID;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIN0_W-1:0] quo_q, quo_d;
  logic [DIN1_W-1:0] acc_q, acc_d;
  logic [DIN1_W-1:0] div_q, div_d;
  logic              sign0_q, sign0_d;
  logic              sign1_q, sign1_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic [DIN1_W-1:0] rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic              dz_q, dz_d;

  logic [DIN1_W-1:0] step_rem;
  logic              step_qbit;

  // quo_q doubles as the dividend shifter: its MSB feeds the step, quotient bits enter at the LSB.
  network_div_step u_step (
    .rem_in  (acc_q),
    .bit_in  (quo_q[DIN0_W-1]),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    acc_d   = acc_q;
    div_d   = div_q;
    sign0_d = sign0_q;
    sign1_d = sign1_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign0_d = din0[DIN0_W-1];
          sign1_d = din1[DIN1_W-1];
          quo_d   = din0[DIN0_W-1] ? (~din0 + 29'd1) : din0;
          div_d   = din1[DIN1_W-1] ? (~din1 + 13'd1) : din1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        quo_d = {quo_q[DIN0_W-2:0], step_qbit};
        acc_d = step_rem;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        ovf_d = 1'b0;
        dz_d  = 1'b0;
        if (div_q == '0) begin
          dz_d   = 1'b1;
          rem_d  = '0;
          dout_d = sign0_q ? Q_MIN : Q_MAX;
        end else begin
          rem_d = sign0_q ? (~acc_q + 13'd1) : acc_q;
          if (sign0_q ^ sign1_q) begin
            if (quo_q > MAG_NEG_LIM) begin
              ovf_d  = 1'b1;
              dout_d = Q_MIN;
            end else begin
              dout_d = ~quo_q[DOUT_W-1:0] + 16'd1;
            end
          end else if (quo_q > MAG_POS_LIM) begin
            ovf_d  = 1'b1;
            dout_d = Q_MAX;
          end else begin
            dout_d = quo_q[DOUT_W-1:0];
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over ce; otherwise nothing moves unless ce is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      acc_q   <= '0;
      div_q   <= '0;
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      sign0_q <= sign0_d;
      sign1_q <= sign1_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout      = dout_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule
